// File: rtl/last_value_predictor_pkg.sv
// Shared types for the last-value load predictor:
// table entry layout, FSM states and derived field widths.
package last_value_predictor_pkg;

  localparam int LVP_ENTRIES     = 16;
  localparam int LVP_DATA_W      = 32;
  localparam int LVP_CONF_BITS   = 2;
  localparam int LVP_CONF_THRESH = 2;

  localparam int LVP_IDX_W = $clog2(LVP_ENTRIES);
  localparam int LVP_TAG_W = LVP_DATA_W - 2 - LVP_IDX_W;

  typedef enum logic {
    LVP_IDLE = 1'b0,
    LVP_WAIT = 1'b1
  } lvp_state_e;

  typedef struct packed {
    logic                     valid;
    logic [LVP_TAG_W-1:0]     tag;
    logic [LVP_DATA_W-1:0]    value;
    logic [LVP_CONF_BITS-1:0] conf;
  } lvp_entry_t;

  function automatic logic [LVP_CONF_BITS-1:0] lvp_conf_inc(
    input logic [LVP_CONF_BITS-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/last_value_predictor_table.sv
// Predictor entry array: one combinational read port,
// one synchronous write port, cleared on reset.
module lvp_table
  import last_value_predictor_pkg::*;
#(
  parameter int ENTRIES = LVP_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output lvp_entry_t       o_rd_entry,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  lvp_entry_t       i_wr_entry
);

  lvp_entry_t r_mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_entry;
    end
  end

  assign o_rd_entry = r_mem[i_rd_idx];

endmodule

// File: rtl/last_value_predictor.sv
// Last-value load predictor: predicts a missing load's value,
// verifies it on D-cache return, trains and requests recovery.
module last_value_predictor
  import last_value_predictor_pkg::*;
#(
  parameter int ENTRIES     = LVP_ENTRIES,
  parameter int DATA_WIDTH  = LVP_DATA_W,
  parameter int CONF_BITS   = LVP_CONF_BITS,
  parameter int CONF_THRESH = LVP_CONF_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_valid,
  input  logic [DATA_WIDTH-1:0] lookup_pc,
  output logic                  lookup_ready,
  output logic                  pred_valid,
  output logic [DATA_WIDTH-1:0] pred_data,
  output logic                  pred_confident,
  input  logic                  resolve_valid,
  input  logic [DATA_WIDTH-1:0] resolve_data,
  input  logic                  flush,
  output logic                  verify_valid,
  output logic                  verify_hit,
  output logic                  recover,
  output logic [15:0]           pred_count,
  output logic [15:0]           hit_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = DATA_WIDTH - 2 - IDX_W;
  localparam logic [CONF_BITS-1:0] THRESH =
    CONF_BITS'(CONF_THRESH);

  lvp_state_e       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_verify_valid;
  logic             r_verify_hit;
  logic             r_recover;
  logic [15:0]      r_pred_count;
  logic [15:0]      r_hit_count;

  lvp_entry_t w_rd;
  lvp_entry_t w_wr;
  logic       w_accept;
  logic       w_resolve;
  logic       w_hit;
  logic       w_match;
  logic       w_conf;
  logic       w_unused;

  // Word-aligned PCs: the byte offset never selects an entry.
  assign w_unused = ^lookup_pc[1:0];

  assign w_accept  = (r_state == LVP_IDLE) & lookup_valid;
  assign w_resolve = (r_state == LVP_WAIT) & resolve_valid
                   & ~flush;

  assign w_hit   = w_rd.valid & (w_rd.tag == r_tag);
  assign w_match = w_hit & (w_rd.value == resolve_data);
  assign w_conf  = w_hit & (w_rd.conf >= THRESH);

  always_comb begin
    w_wr       = '0;
    w_wr.valid = 1'b1;
    w_wr.tag   = r_tag;
    w_wr.value = resolve_data;
    w_wr.conf  = w_match ? lvp_conf_inc(w_rd.conf) : '0;
  end

  lvp_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (r_idx),
    .o_rd_entry (w_rd),
    .i_wr_en    (w_resolve),
    .i_wr_idx   (r_idx),
    .i_wr_entry (w_wr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LVP_IDLE;
    end else begin
      unique case (1'b1)
        w_accept:  r_state <= LVP_WAIT;
        r_state == LVP_WAIT && (flush || resolve_valid):
                   r_state <= LVP_IDLE;
        default:   r_state <= r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      r_tag <= '0;
    end else if (w_accept) begin
      r_idx <= lookup_pc[2 +: IDX_W];
      r_tag <= lookup_pc[DATA_WIDTH-1:2+IDX_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_verify_valid <= 1'b0;
      r_verify_hit   <= 1'b0;
      r_recover      <= 1'b0;
    end else begin
      r_verify_valid <= w_resolve;
      r_verify_hit   <= w_resolve & w_match;
      r_recover      <= w_resolve & w_conf & ~w_match;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pred_count <= '0;
      r_hit_count  <= '0;
    end else if (w_resolve) begin
      if (r_pred_count != 16'hFFFF)
        r_pred_count <= r_pred_count + 16'd1;
      if (w_match && r_hit_count != 16'hFFFF)
        r_hit_count <= r_hit_count + 16'd1;
    end
  end

  assign lookup_ready   = (r_state == LVP_IDLE);
  assign pred_valid     = (r_state == LVP_WAIT);
  assign pred_data      = (pred_valid && w_hit) ? w_rd.value : '0;
  assign pred_confident = pred_valid & w_conf;
  assign verify_valid   = r_verify_valid;
  assign verify_hit     = r_verify_hit;
  assign recover        = r_recover;
  assign pred_count     = r_pred_count;
  assign hit_count      = r_hit_count;

endmodule

// File: tb/tb_last_value_predictor.sv
// Directed bench for last_value_predictor: cold miss, training,
// confident mispredict, aliasing, flush and reset mid-WAIT.
module tb_last_value_predictor;

  logic        clk;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        lookup_ready;
  logic        pred_valid;
  logic [31:0] pred_data;
  logic        pred_confident;
  logic        resolve_valid;
  logic [31:0] resolve_data;
  logic        flush;
  logic        verify_valid;
  logic        verify_hit;
  logic        recover;
  logic [15:0] pred_count;
  logic [15:0] hit_count;

  int total;
  int bad;

  last_value_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .lookup_valid   (lookup_valid),
    .lookup_pc      (lookup_pc),
    .lookup_ready   (lookup_ready),
    .pred_valid     (pred_valid),
    .pred_data      (pred_data),
    .pred_confident (pred_confident),
    .resolve_valid  (resolve_valid),
    .resolve_data   (resolve_data),
    .flush          (flush),
    .verify_valid   (verify_valid),
    .verify_hit     (verify_hit),
    .recover        (recover),
    .pred_count     (pred_count),
    .hit_count      (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    tick();
    lookup_valid = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] d);
    resolve_valid = 1'b1;
    resolve_data  = d;
    tick();
    resolve_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({lookup_ready, pred_valid, pred_confident,
         verify_valid, verify_hit, recover} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=100000",
        {lookup_ready, pred_valid, pred_confident,
         verify_valid, verify_hit, recover});
    end
    total++;
    if (pred_data !== 32'd0 || pred_count !== 16'd0
        || hit_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_values data=%h pc=%0d hc=%0d want 0",
        pred_data, pred_count, hit_count);
    end
  endtask

  task automatic test_cold_miss;
    lookup(32'h100);
    total++;
    if ({pred_valid, lookup_ready, pred_confident} !== 3'b100
        || pred_data !== 32'd0) begin
      bad++;
      $display("FAIL cold_pred v/r/c=%b data=%h want 100/0",
        {pred_valid, lookup_ready, pred_confident}, pred_data);
    end
    resolve(32'hDEAD);
    total++;
    if ({verify_valid, verify_hit, recover, lookup_ready}
        !== 4'b1001) begin
      bad++;
      $display("FAIL cold_verify got=%b want=1001",
        {verify_valid, verify_hit, recover, lookup_ready});
    end
    total++;
    if (pred_count !== 16'd1 || hit_count !== 16'd0) begin
      bad++;
      $display("FAIL cold_counts pc=%0d hc=%0d want 1/0",
        pred_count, hit_count);
    end
    tick();
    total++;
    if (verify_valid !== 1'b0) begin
      bad++;
      $display("FAIL cold_pulse_width got=%b want=0",
        verify_valid);
    end
  endtask

  // Conf runs 0,1,2,3,3: confident from the third lookup on,
  // and a wrap past 3 would drop confidence on the fifth.
  task automatic test_train;
    logic [3:0] exp_conf;
    exp_conf = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      lookup(32'h100);
      total++;
      if (pred_data !== 32'hDEAD
          || pred_confident !== exp_conf[i]) begin
        bad++;
        $display("FAIL train_pred%0d data=%h c=%b want DEAD/%b",
          i, pred_data, pred_confident, exp_conf[i]);
      end
      resolve(32'hDEAD);
      total++;
      if ({verify_valid, verify_hit, recover} !== 3'b110
          || hit_count !== 16'(i + 1)
          || lookup_ready !== 1'b1) begin
        bad++;
        $display("FAIL train_verify%0d vhr=%b hc=%0d rdy=%b",
          i, {verify_valid, verify_hit, recover},
          hit_count, lookup_ready);
      end
    end
    total++;
    if (pred_count !== 16'd5 || hit_count !== 16'd4) begin
      bad++;
      $display("FAIL train_counts pc=%0d hc=%0d want 5/4",
        pred_count, hit_count);
    end
  endtask

  task automatic test_mispredict;
    lookup(32'h100);
    total++;
    if (pred_data !== 32'hDEAD || pred_confident !== 1'b1) begin
      bad++;
      $display("FAIL sat_conf data=%h c=%b want DEAD/1",
        pred_data, pred_confident);
    end
    resolve(32'hBEEF);
    total++;
    if ({verify_valid, verify_hit, recover} !== 3'b101
        || pred_count !== 16'd6 || hit_count !== 16'd4) begin
      bad++;
      $display("FAIL mis_verify vhr=%b pc=%0d hc=%0d want 101/6/4",
        {verify_valid, verify_hit, recover}, pred_count, hit_count);
    end
    tick();
    total++;
    if (recover !== 1'b0) begin
      bad++;
      $display("FAIL mis_pulse got=%b want=0", recover);
    end
    lookup(32'h100);
    total++;
    if (pred_data !== 32'hBEEF || pred_confident !== 1'b0) begin
      bad++;
      $display("FAIL mis_retrain data=%h c=%b want BEEF/0",
        pred_data, pred_confident);
    end
    resolve(32'hBEEF);
    total++;
    if ({verify_hit, recover} !== 2'b10 || hit_count !== 16'd5) begin
      bad++;
      $display("FAIL mis_rehit hr=%b hc=%0d want 10/5",
        {verify_hit, recover}, hit_count);
    end
  endtask

  task automatic test_alias;
    lookup(32'h140);
    total++;
    if (pred_data !== 32'd0 || pred_confident !== 1'b0) begin
      bad++;
      $display("FAIL alias_miss data=%h c=%b want 0/0",
        pred_data, pred_confident);
    end
    resolve(32'h1);
    total++;
    if ({verify_valid, verify_hit, recover} !== 3'b100) begin
      bad++;
      $display("FAIL alias_verify got=%b want=100",
        {verify_valid, verify_hit, recover});
    end
    lookup(32'h100);
    total++;
    if (pred_data !== 32'd0) begin
      bad++;
      $display("FAIL alias_evict data=%h want 0", pred_data);
    end
    resolve(32'hDEAD);
  endtask

  task automatic test_flush;
    lookup(32'h100);
    flush         = 1'b1;
    resolve_valid = 1'b1;
    resolve_data  = 32'h1234;
    tick();
    flush         = 1'b0;
    resolve_valid = 1'b0;
    total++;
    if ({verify_valid, lookup_ready, pred_valid} !== 3'b010
        || pred_count !== 16'd9 || hit_count !== 16'd5) begin
      bad++;
      $display("FAIL flush_wins vrp=%b pc=%0d hc=%0d want 010/9/5",
        {verify_valid, lookup_ready, pred_valid},
        pred_count, hit_count);
    end
    flush         = 1'b1;
    resolve_valid = 1'b1;
    tick();
    flush         = 1'b0;
    resolve_valid = 1'b0;
    total++;
    if (verify_valid !== 1'b0 || lookup_ready !== 1'b1
        || pred_count !== 16'd9) begin
      bad++;
      $display("FAIL idle_ignore v=%b r=%b pc=%0d want 0/1/9",
        verify_valid, lookup_ready, pred_count);
    end
    lookup(32'h100);
    total++;
    if (pred_data !== 32'hDEAD) begin
      bad++;
      $display("FAIL flush_entry data=%h want DEAD", pred_data);
    end
    resolve(32'hDEAD);
    total++;
    if (verify_hit !== 1'b1 || pred_count !== 16'd10
        || hit_count !== 16'd6) begin
      bad++;
      $display("FAIL flush_after h=%b pc=%0d hc=%0d want 1/10/6",
        verify_hit, pred_count, hit_count);
    end
  endtask

  task automatic test_reset_mid_wait;
    lookup(32'h100);
    rst           = 1'b1;
    resolve_valid = 1'b1;
    resolve_data  = 32'h77;
    tick();
    rst           = 1'b0;
    resolve_valid = 1'b0;
    total++;
    if ({lookup_ready, pred_valid, verify_valid, recover}
        !== 4'b1000 || pred_count !== 16'd0
        || hit_count !== 16'd0) begin
      bad++;
      $display("FAIL rst_wait rpvr=%b pc=%0d hc=%0d want 1000/0/0",
        {lookup_ready, pred_valid, verify_valid, recover},
        pred_count, hit_count);
    end
    lookup(32'h100);
    total++;
    if (pred_data !== 32'd0 || pred_confident !== 1'b0) begin
      bad++;
      $display("FAIL rst_cleared data=%h c=%b want 0/0",
        pred_data, pred_confident);
    end
    resolve(32'h0);
  endtask

  // Neighbouring index stays separate; byte offset is ignored.
  task automatic test_index;
    lookup(32'h104);
    resolve(32'h55);
    lookup(32'h107);
    total++;
    if (pred_data !== 32'h55) begin
      bad++;
      $display("FAIL idx_offset data=%h want 55", pred_data);
    end
    resolve(32'h55);
    lookup(32'h100);
    total++;
    if (pred_data !== 32'h0) begin
      bad++;
      $display("FAIL idx_separate data=%h want 0", pred_data);
    end
    resolve(32'h0);
    total++;
    if (verify_hit !== 1'b1 || pred_count !== 16'd4
        || hit_count !== 16'd2) begin
      bad++;
      $display("FAIL idx_counts h=%b pc=%0d hc=%0d want 1/4/2",
        verify_hit, pred_count, hit_count);
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b0;
    lookup_valid  = 1'b0;
    lookup_pc     = '0;
    resolve_valid = 1'b0;
    resolve_data  = '0;
    flush         = 1'b0;
    test_reset();
    test_cold_miss();
    test_train();
    test_mispredict();
    test_alias();
    test_flush();
    test_reset_mid_wait();
    test_index();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
